// File: rtl/task_out_packetizer.sv
// Output stage for task blocks: buffers result words in a FWFT FIFO, delimits them
// into packets (explicit last or max length) and streams each packet to the manager.
module task_out_packetizer #(
  parameter int DATA_WIDTH       = 8,
  parameter int DEPTH            = 64,
  parameter int MAX_PACKET_WORDS = 16,
  parameter int LEN_DEPTH        = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic                  i_input_last,
  output logic                  o_in_ready,
  output logic                  o_full,
  input  logic                  i_tmanager_ready,
  output logic                  o_tanswer_ready,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tanswer_data_last,
  output logic [11:0]           o_packet_size_in_bytes,
  output logic                  o_busy
);

  localparam int DAW = $clog2(DEPTH);
  localparam int LW  = $clog2(MAX_PACKET_WORDS + 1);
  localparam int LAW = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;
  localparam int LCW = $clog2(LEN_DEPTH + 1);
  localparam logic [11:0] BYTES_PER_WORD = 12'(DATA_WIDTH / 8);

  typedef enum logic [1:0] {S_IDLE, S_START, S_SEND} state_t;
  state_t state;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DAW-1:0]        wr_ptr, rd_ptr;
  logic [DAW:0]          data_cnt;

  logic [LW-1:0]         len_q [LEN_DEPTH];
  logic [LAW-1:0]        len_wr, len_rd;
  logic [LCW-1:0]        len_cnt;

  logic [LW-1:0]         wr_len, r_len, rd_cnt;
  logic [11:0]           size_q;

  logic wr_accept, pkt_close, beat, beat_last, len_pop;

  assign o_full     = (data_cnt == (DAW+1)'(DEPTH)) || (len_cnt == LCW'(LEN_DEPTH));
  assign o_in_ready = !o_full;

  assign wr_accept = i_data_valid && o_in_ready;
  assign pkt_close = wr_accept && (i_input_last || (wr_len == LW'(MAX_PACKET_WORDS - 1)));
  assign len_pop   = (state == S_START);
  assign beat      = (state == S_SEND) && i_tmanager_ready;
  assign beat_last = (rd_cnt == r_len - LW'(1));

  assign o_tanswer_ready        = (state == S_SEND);
  assign o_tdata                = (state == S_SEND) ? mem[rd_ptr] : '0;
  assign o_tanswer_data_last    = (state == S_SEND) && beat_last;
  assign o_packet_size_in_bytes = size_q;
  assign o_busy                 = (state != S_IDLE);

  // Storage arrays carry no reset; stale contents are never exposed because
  // the read side is gated by the counts and the FSM state.
  always_ff @(posedge i_clk) begin
    if (wr_accept) mem[wr_ptr] <= i_data;
    if (pkt_close) len_q[len_wr] <= wr_len + LW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_cnt <= '0;
      len_wr   <= '0;
      len_rd   <= '0;
      len_cnt  <= '0;
      wr_len   <= '0;
      r_len    <= '0;
      rd_cnt   <= '0;
      size_q   <= '0;
      state    <= S_IDLE;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + DAW'(1);
        wr_len <= pkt_close ? '0 : wr_len + LW'(1);
      end
      if (beat) rd_ptr <= rd_ptr + DAW'(1);

      case ({wr_accept, beat})
        2'b10:   data_cnt <= data_cnt + (DAW+1)'(1);
        2'b01:   data_cnt <= data_cnt - (DAW+1)'(1);
        default: ;
      endcase

      if (pkt_close) len_wr <= (len_wr == LAW'(LEN_DEPTH - 1)) ? '0 : len_wr + LAW'(1);
      if (len_pop)   len_rd <= (len_rd == LAW'(LEN_DEPTH - 1)) ? '0 : len_rd + LAW'(1);

      case ({pkt_close, len_pop})
        2'b10:   len_cnt <= len_cnt + LCW'(1);
        2'b01:   len_cnt <= len_cnt - LCW'(1);
        default: ;
      endcase

      case (state)
        S_IDLE: begin
          if (len_cnt != '0) state <= S_START;
        end
        S_START: begin
          r_len  <= len_q[len_rd];
          size_q <= 12'(len_q[len_rd]) * BYTES_PER_WORD;
          rd_cnt <= '0;
          state  <= S_SEND;
        end
        S_SEND: begin
          if (beat) begin
            rd_cnt <= rd_cnt + LW'(1);
            if (beat_last) begin
              size_q <= '0;
              state  <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
